// File: rtl/lc3b_branch_predictor_pkg.sv
// Shared types and constants for the LC-3b dynamic branch predictor.
// Holds the predictor mode enum and the counter reset-value helper.
package lc3b_types;

    typedef enum logic {
        BP_BIMODAL = 1'b0,
        BP_GSHARE  = 1'b1
    } lc3b_bp_mode;

    // Zero history bits means the table is indexed by PC alone.
    function automatic lc3b_bp_mode bp_mode(input int history_bits);
        return (history_bits == 0) ? BP_BIMODAL : BP_GSHARE;
    endfunction

    // Weakly-not-taken: one below the taken threshold (01 for 2 bits).
    function automatic int weak_not_taken(input int counter_bits);
        return (1 << (counter_bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/lc3b_branch_predictor_pattern_history_table.sv
// Pattern history table of saturating counters, one read and one update port.
// Ports: clk, reset, rd_index -> rd_taken (counter MSB); wr_en/wr_index/wr_taken.
module pattern_history_table
    import lc3b_types::*;
#(
    parameter int INDEX_BITS   = 4,
    parameter int COUNTER_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_taken,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  wr_taken
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [COUNTER_BITS-1:0] CTR_MAX = '1;
    localparam logic [COUNTER_BITS-1:0] CTR_MIN = '0;
    localparam logic [COUNTER_BITS-1:0] CTR_RST =
        COUNTER_BITS'(weak_not_taken(COUNTER_BITS));

    logic [COUNTER_BITS-1:0] ctr [ENTRIES];
    logic [COUNTER_BITS-1:0] cur;

    // Read sees the registered value, so a same-cycle update is not bypassed.
    assign rd_taken = ctr[rd_index][COUNTER_BITS-1];
    assign cur      = ctr[wr_index];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_RST;
            end
        end else if (wr_en) begin
            if (wr_taken && cur != CTR_MAX) begin
                ctr[wr_index] <= cur + 1'b1;
            end else if (!wr_taken && cur != CTR_MIN) begin
                ctr[wr_index] <= cur - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lc3b_branch_predictor.sv
// Dynamic branch predictor (bimodal or gshare) for the pipelined LC-3b.
// Ports: stage_IF_pc -> branch_prediction/prediction_index; resolve_* update; stats.
module lc3b_branch_predictor
    import lc3b_types::*;
#(
    parameter int INDEX_BITS   = 4,
    parameter int HISTORY_BITS = 0,
    parameter int COUNTER_BITS = 2,
    parameter int STAT_BITS    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           stage_IF_pc,
    output logic                  branch_prediction,
    output logic [INDEX_BITS-1:0] prediction_index,
    input  logic                  resolve_valid,
    input  logic [INDEX_BITS-1:0] resolve_index,
    input  logic                  resolve_taken,
    input  logic                  resolve_prediction,
    input  logic                  stat_clear,
    output logic                  mispredict,
    output logic [STAT_BITS-1:0]  stat_branches,
    output logic [STAT_BITS-1:0]  stat_mispredicts
);

    localparam lc3b_bp_mode MODE = bp_mode(HISTORY_BITS);

    if (HISTORY_BITS > INDEX_BITS || HISTORY_BITS < 0) begin : g_bad_hist
        $error("HISTORY_BITS must be in 0..INDEX_BITS");
    end
    if (COUNTER_BITS < 1) begin : g_bad_ctr
        $error("COUNTER_BITS must be at least 1");
    end

    logic [INDEX_BITS-1:0] pc_index;
    logic                  unused_pc;

    // Bit 0 is always zero for word-aligned fetch; upper bits are not hashed.
    assign pc_index  = stage_IF_pc[INDEX_BITS:1];
    assign unused_pc = ^stage_IF_pc;

    if (MODE == BP_GSHARE) begin : g_gshare
        logic [HISTORY_BITS-1:0] ghr;

        assign prediction_index = pc_index ^ INDEX_BITS'(ghr);

        // History is committed only at resolve, so it never needs repair.
        always_ff @(posedge clk) begin
            if (reset) begin
                ghr <= '0;
            end else if (resolve_valid) begin
                ghr <= HISTORY_BITS'({ghr, resolve_taken});
            end
        end
    end else begin : g_bimodal
        assign prediction_index = pc_index;
    end

    pattern_history_table #(
        .INDEX_BITS   (INDEX_BITS),
        .COUNTER_BITS (COUNTER_BITS)
    ) u_pht (
        .clk      (clk),
        .reset    (reset),
        .rd_index (prediction_index),
        .rd_taken (branch_prediction),
        .wr_en    (resolve_valid),
        .wr_index (resolve_index),
        .wr_taken (resolve_taken)
    );

    assign mispredict = resolve_valid && (resolve_prediction != resolve_taken);

    localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset || stat_clear) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve_valid && stat_branches != STAT_MAX) begin
                stat_branches <= stat_branches + 1'b1;
            end
            if (mispredict && stat_mispredicts != STAT_MAX) begin
                stat_mispredicts <= stat_mispredicts + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lc3b_branch_predictor.sv
// Directed self-checking bench for lc3b_branch_predictor.
// Drives a bimodal instance (STAT_BITS=4) and a gshare instance in lockstep.
module tb_lc3b_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] stage_IF_pc;
    logic        resolve_valid;
    logic [3:0]  resolve_index;
    logic        resolve_taken;
    logic        resolve_prediction;
    logic        stat_clear;

    logic        b_pred, g_pred;
    logic [3:0]  b_idx, g_idx;
    logic        b_misp, g_misp;
    logic [3:0]  b_br, b_mp;
    logic [15:0] g_br, g_mp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3b_branch_predictor #(
        .INDEX_BITS(4), .HISTORY_BITS(0), .COUNTER_BITS(2), .STAT_BITS(4)
    ) dut_b (
        .clk(clk), .reset(reset), .stage_IF_pc(stage_IF_pc),
        .branch_prediction(b_pred), .prediction_index(b_idx),
        .resolve_valid(resolve_valid), .resolve_index(resolve_index),
        .resolve_taken(resolve_taken), .resolve_prediction(resolve_prediction),
        .stat_clear(stat_clear), .mispredict(b_misp),
        .stat_branches(b_br), .stat_mispredicts(b_mp)
    );

    lc3b_branch_predictor #(
        .INDEX_BITS(4), .HISTORY_BITS(2), .COUNTER_BITS(2), .STAT_BITS(16)
    ) dut_g (
        .clk(clk), .reset(reset), .stage_IF_pc(stage_IF_pc),
        .branch_prediction(g_pred), .prediction_index(g_idx),
        .resolve_valid(resolve_valid), .resolve_index(resolve_index),
        .resolve_taken(resolve_taken), .resolve_prediction(resolve_prediction),
        .stat_clear(stat_clear), .mispredict(g_misp),
        .stat_branches(g_br), .stat_mispredicts(g_mp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        resolve_valid      = 1'b0;
        resolve_index      = 4'd0;
        resolve_taken      = 1'b0;
        resolve_prediction = 1'b0;
        stat_clear         = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic resolve(input logic [3:0] idx, input logic tk,
                           input logic pr);
        resolve_valid      = 1'b1;
        resolve_index      = idx;
        resolve_taken      = tk;
        resolve_prediction = pr;
        step();
        idle();
        #1;
    endtask

    task automatic test_reset();
        idle();
        stage_IF_pc = 16'h0000;
        reset = 1'b1;
        // A resolve in the reset cycle must be dropped.
        resolve_valid = 1'b1;
        resolve_index = 4'd5;
        resolve_taken = 1'b1;
        step();
        reset = 1'b0;
        idle();
        #1;
        for (int pc = 0; pc <= 'h1E; pc += 2) begin
            stage_IF_pc = 16'(pc);
            #1;
            checks++;
            if (b_pred !== 1'b0 || g_pred !== 1'b0) begin
                errors++;
                $display("FAIL reset_pred pc=%h got b=%b g=%b want 0",
                         stage_IF_pc, b_pred, g_pred);
            end
        end
        checks++;
        if (b_br !== 4'd0 || b_mp !== 4'd0) begin
            errors++;
            $display("FAIL reset_stats got %0d/%0d want 0/0", b_br, b_mp);
        end
        checks++;
        if (g_br !== 16'd0 || g_mp !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats_g got %0d/%0d want 0/0", g_br, g_mp);
        end
    endtask

    task automatic test_bimodal();
        do_reset();
        stage_IF_pc = 16'h0006;
        resolve(4'd3, 1'b1, 1'b0);
        checks++;
        if (b_pred !== 1'b1) begin
            errors++;
            $display("FAIL bim_first_taken got %b want 1", b_pred);
        end
        checks++;
        if (b_idx !== 4'd3) begin
            errors++;
            $display("FAIL bim_index got %0d want 3", b_idx);
        end
        for (int i = 0; i < 4; i++) resolve(4'd3, 1'b1, 1'b1);
        resolve(4'd3, 1'b0, 1'b1);
        checks++;
        if (b_pred !== 1'b1) begin
            errors++;
            $display("FAIL bim_sat_hold got %b want 1", b_pred);
        end
        resolve(4'd3, 1'b0, 1'b1);
        checks++;
        if (b_pred !== 1'b0) begin
            errors++;
            $display("FAIL bim_flip got %b want 0", b_pred);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        resolve_valid      = 1'b1;
        resolve_index      = 4'd1;
        resolve_taken      = 1'b1;
        resolve_prediction = 1'b0;
        #1;
        checks++;
        if (b_misp !== 1'b1 || g_misp !== 1'b1) begin
            errors++;
            $display("FAIL misp_comb got %b/%b want 1", b_misp, g_misp);
        end
        step();
        idle();
        #1;
        checks++;
        if (b_br !== 4'd1 || b_mp !== 4'd1) begin
            errors++;
            $display("FAIL misp_stats got %0d/%0d want 1/1", b_br, b_mp);
        end
        resolve_valid      = 1'b1;
        resolve_index      = 4'd1;
        resolve_taken      = 1'b1;
        resolve_prediction = 1'b1;
        #1;
        checks++;
        if (b_misp !== 1'b0) begin
            errors++;
            $display("FAIL misp_correct got %b want 0", b_misp);
        end
        step();
        idle();
        #1;
        checks++;
        if (b_br !== 4'd2 || b_mp !== 4'd1) begin
            errors++;
            $display("FAIL correct_stats got %0d/%0d want 2/1", b_br, b_mp);
        end
        checks++;
        if (b_misp !== 1'b0) begin
            errors++;
            $display("FAIL misp_idle got %b want 0", b_misp);
        end
    endtask

    task automatic test_gshare();
        do_reset();
        resolve(4'd9, 1'b1, 1'b0);
        resolve(4'd9, 1'b1, 1'b0);
        stage_IF_pc = 16'h0000;
        #1;
        checks++;
        if (g_idx !== 4'd3) begin
            errors++;
            $display("FAIL gshare_pc0 got %0d want 3", g_idx);
        end
        stage_IF_pc = 16'h0006;
        #1;
        checks++;
        if (g_idx !== 4'd0) begin
            errors++;
            $display("FAIL gshare_pc6 got %0d want 0", g_idx);
        end
        checks++;
        if (b_idx !== 4'd3) begin
            errors++;
            $display("FAIL bimodal_pc6 got %0d want 3", b_idx);
        end
    endtask

    task automatic test_collision();
        do_reset();
        stage_IF_pc        = 16'h000A;
        resolve_valid      = 1'b1;
        resolve_index      = 4'd5;
        resolve_taken      = 1'b1;
        resolve_prediction = 1'b0;
        #1;
        checks++;
        if (b_pred !== 1'b0) begin
            errors++;
            $display("FAIL collide_same got %b want 0", b_pred);
        end
        step();
        idle();
        #1;
        checks++;
        if (b_pred !== 1'b1) begin
            errors++;
            $display("FAIL collide_next got %b want 1", b_pred);
        end
    endtask

    task automatic test_stat_saturation();
        do_reset();
        resolve_valid      = 1'b1;
        resolve_index      = 4'd0;
        resolve_taken      = 1'b1;
        resolve_prediction = 1'b0;
        for (int i = 0; i < 20; i++) step();
        idle();
        #1;
        checks++;
        if (b_br !== 4'd15 || b_mp !== 4'd15) begin
            errors++;
            $display("FAIL stat_sat got %0d/%0d want 15/15", b_br, b_mp);
        end
        checks++;
        if (g_br !== 16'd20 || g_mp !== 16'd20) begin
            errors++;
            $display("FAIL stat_wide got %0d/%0d want 20/20", g_br, g_mp);
        end
        stage_IF_pc = 16'h000E;
        #1;
        checks++;
        if (b_pred !== 1'b0) begin
            errors++;
            $display("FAIL pre_clear_pred got %b want 0", b_pred);
        end
        stat_clear         = 1'b1;
        resolve_valid      = 1'b1;
        resolve_index      = 4'd7;
        resolve_taken      = 1'b1;
        resolve_prediction = 1'b0;
        step();
        idle();
        #1;
        checks++;
        if (b_br !== 4'd0 || b_mp !== 4'd0) begin
            errors++;
            $display("FAIL clear_stats got %0d/%0d want 0/0", b_br, b_mp);
        end
        checks++;
        if (g_br !== 16'd0 || g_mp !== 16'd0) begin
            errors++;
            $display("FAIL clear_stats_g got %0d/%0d want 0/0", g_br, g_mp);
        end
        checks++;
        if (b_pred !== 1'b1) begin
            errors++;
            $display("FAIL clear_pht got %b want 1", b_pred);
        end
    endtask

    initial begin
        reset       = 1'b1;
        stage_IF_pc = 16'h0000;
        idle();
        step();
        test_reset();
        test_bimodal();
        test_mispredict();
        test_gshare();
        test_collision();
        test_stat_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
